// File: rtl/axis_length_checker.sv
// rtl/axis_length_checker.sv - AXI-Stream register stage with per-packet beat-count checking
// Flags short/long packets and upstream errors per beat, with saturating packet/error counters.
module axis_length_checker #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int MIN_BEATS      = 1,
  parameter int MAX_BEATS      = 1518,
  parameter int STAT_BITS      = 32
) (
  input  logic                      clk,
  input  logic                      sreset,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_i_error,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_error,
  output logic [STAT_BITS-1:0]      stat_pkts,
  output logic [STAT_BITS-1:0]      stat_errs
);

  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);
  localparam logic [CW:0]   MAX_N   = (CW + 1)'(MAX_BEATS);
  localparam logic [CW:0]   MIN_N   = (CW + 1)'(MIN_BEATS);
  localparam logic [STAT_BITS-1:0] STAT_ONE = STAT_BITS'(1);

  logic [CW-1:0] beat_cnt;
  logic [CW:0]   beat_n;
  logic          err_sticky;
  logic          err_now;
  logic          in_accept;

  assign axis_i_tready = !axis_o_tvalid || axis_o_tready;
  assign in_accept     = axis_i_tvalid && axis_i_tready;

  // beat_n is one bit wider so the saturated count plus one cannot wrap
  assign beat_n  = {1'b0, beat_cnt} + (CW + 1)'(1);
  assign err_now = axis_i_error || (beat_n > MAX_N) ||
                   (axis_i_tlast && (beat_n < MIN_N)) || err_sticky;

  always_ff @(posedge clk) begin
    if (sreset) begin
      beat_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (in_accept) begin
      if (axis_i_tlast) begin
        beat_cnt   <= '0;
        err_sticky <= 1'b0;
      end else begin
        if (beat_cnt != CNT_SAT) beat_cnt <= beat_cnt + CW'(1);
        if (err_now) err_sticky <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tdata  <= '0;
      axis_o_tuser  <= '0;
      axis_o_error  <= 1'b0;
    end else if (in_accept) begin
      axis_o_tvalid <= 1'b1;
      axis_o_tlast  <= axis_i_tlast;
      axis_o_tdata  <= axis_i_tdata;
      axis_o_tuser  <= axis_i_tuser;
      axis_o_error  <= err_now;
    end else if (axis_o_tready) begin
      axis_o_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      stat_pkts <= '0;
      stat_errs <= '0;
    end else if (in_accept && axis_i_tlast) begin
      if (stat_pkts != '1) stat_pkts <= stat_pkts + STAT_ONE;
      if (err_now && (stat_errs != '1)) stat_errs <= stat_errs + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_axis_length_checker.sv
// tb/tb_axis_length_checker.sv - randomized self-checking bench for axis_length_checker
// Expected beats come from a packet-level model: each beat's error is the prefix OR of its rule violations.
module tb_axis_length_checker;
  localparam int MINB = 4;
  localparam int MAXB = 8;
  localparam int SB   = 4;
  localparam int SMAX = (1 << SB) - 1;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
    logic       err;
  } beat_t;

  logic          clk = 1'b0;
  logic          sreset = 1'b1;
  logic          axis_i_tready;
  logic          axis_i_tvalid = 1'b0;
  logic          axis_i_tlast = 1'b0;
  logic [7:0]    axis_i_tdata = '0;
  logic [0:0]    axis_i_tuser = '0;
  logic          axis_i_error = 1'b0;
  logic          axis_o_tready = 1'b1;
  logic          axis_o_tvalid;
  logic          axis_o_tlast;
  logic [7:0]    axis_o_tdata;
  logic [0:0]    axis_o_tuser;
  logic          axis_o_error;
  logic [SB-1:0] stat_pkts;
  logic [SB-1:0] stat_errs;

  always #5 clk = ~clk;

  axis_length_checker #(
    .AXIS_BYTES(1), .AXIS_USER_BITS(1), .MIN_BEATS(MINB), .MAX_BEATS(MAXB), .STAT_BITS(SB)
  ) dut (
    .clk(clk), .sreset(sreset),
    .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid), .axis_i_tlast(axis_i_tlast),
    .axis_i_tdata(axis_i_tdata), .axis_i_tuser(axis_i_tuser), .axis_i_error(axis_i_error),
    .axis_o_tready(axis_o_tready), .axis_o_tvalid(axis_o_tvalid), .axis_o_tlast(axis_o_tlast),
    .axis_o_tdata(axis_o_tdata), .axis_o_tuser(axis_o_tuser), .axis_o_error(axis_o_error),
    .stat_pkts(stat_pkts), .stat_errs(stat_errs)
  );

  int vectors = 0;
  int miscompares = 0;
  beat_t inq[$];
  beat_t expq[$];
  int m_pkts = 0;
  int m_errs = 0;
  bit stalled = 0;
  bit prev_acc = 0;
  logic [9:0] snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic gen_pkt(input int len, input bit has_last, input int errpos, input int err_pct);
    beat_t b;
    bit acc;
    acc = 1'b0;
    for (int i = 1; i <= len; i++) begin
      b.data = 8'($urandom_range(0, 255));
      b.user = 1'($urandom_range(0, 1));
      b.last = has_last && (i == len);
      b.err  = (i == errpos) || (int'($urandom_range(0, 99)) < err_pct);
      inq.push_back(b);
      acc = acc | b.err | (i > MAXB) | (b.last && (i < MINB));
      b.err = acc;
      expq.push_back(b);
    end
    if (has_last) begin
      if (m_pkts < SMAX) m_pkts++;
      if (acc && (m_errs < SMAX)) m_errs++;
    end
  endtask

  task automatic step(input bit rnd);
    beat_t e;
    bit acc;
    @(negedge clk);
    if (stalled) check("stall_hold", {axis_o_tvalid, axis_o_tlast, axis_o_tdata}, snap);
    if (prev_acc) check("latency", axis_o_tvalid, 1'b1);
    axis_o_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (inq.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
      axis_i_tvalid = 1'b1;
      axis_i_tdata  = inq[0].data;
      axis_i_tuser  = inq[0].user;
      axis_i_tlast  = inq[0].last;
      axis_i_error  = inq[0].err;
    end else begin
      axis_i_tvalid = 1'b0;
      axis_i_tdata  = 8'($urandom_range(0, 255));
      axis_i_tlast  = 1'($urandom_range(0, 1));
      axis_i_error  = 1'($urandom_range(0, 1));
    end
    #1;
    check("i_tready", axis_i_tready, !axis_o_tvalid || axis_o_tready);
    if (axis_o_tvalid && axis_o_tready) begin
      if (expq.size() == 0) begin
        check("extra_beat", 1'b1, 1'b0);
      end else begin
        e = expq.pop_front();
        check("o_tdata", axis_o_tdata, e.data);
        check("o_tuser", axis_o_tuser, e.user);
        check("o_tlast", axis_o_tlast, e.last);
        check("o_error", axis_o_error, e.err);
      end
    end
    stalled = axis_o_tvalid && !axis_o_tready;
    snap = {axis_o_tvalid, axis_o_tlast, axis_o_tdata};
    acc = axis_i_tvalid && axis_i_tready;
    @(posedge clk);
    if (acc) void'(inq.pop_front());
    prev_acc = acc;
  endtask

  task automatic drain(input bit rnd, input int budget);
    int cyc;
    cyc = 0;
    while ((inq.size() > 0 || expq.size() > 0) && cyc < budget) begin
      step(rnd);
      cyc++;
    end
    if (cyc >= budget) check("drain_timeout", 1'b1, 1'b0);
    step(0);
    step(0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_pkts"}, stat_pkts, m_pkts);
    check({tag, "_errs"}, stat_errs, m_errs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sreset = 1'b1;
    axis_i_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", axis_o_tvalid, 1'b0);
    check("rst_tlast", axis_o_tlast, 1'b0);
    check("rst_tdata", axis_o_tdata, 8'h00);
    check("rst_tuser", axis_o_tuser, 1'b0);
    check("rst_error", axis_o_error, 1'b0);
    check("rst_pkts", stat_pkts, 0);
    check("rst_errs", stat_errs, 0);
    check("rst_i_tready", axis_i_tready, 1'b1);
    sreset = 1'b0;
    inq.delete();
    expq.delete();
    m_pkts = 0;
    m_errs = 0;
    stalled = 0;
    prev_acc = 0;
  endtask

  initial begin
    do_reset();

    gen_pkt(6, 1, 0, 0);
    drain(0, 200);
    check_stats("clean6");

    gen_pkt(10, 1, 0, 0);
    drain(0, 200);
    check_stats("long10");

    gen_pkt(2, 1, 0, 0);
    gen_pkt(4, 1, 0, 0);
    drain(0, 200);
    check_stats("short2");

    gen_pkt(6, 1, 3, 0);
    gen_pkt(6, 1, 0, 0);
    drain(0, 200);
    check_stats("inerr");

    for (int p = 0; p < 20; p++) gen_pkt(int'($urandom_range(1, 5)), 1, 0, 0);
    drain(0, 1000);
    check_stats("sat");
    check("sat_hold", stat_pkts, 4'hF);

    gen_pkt(6, 0, 2, 0);
    inq[$].data = 8'hA5;
    expq[$].data = 8'hA5;
    drain(0, 200);
    do_reset();
    gen_pkt(4, 1, 0, 0);
    drain(0, 200);
    check_stats("post_rst");

    do_reset();
    for (int p = 0; p < 1000; p++) gen_pkt(int'($urandom_range(1, 12)), 1, 0, 3);
    drain(1, 60000);
    check_stats("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
